s2mm_axis_dma: RTL and testbench
================================

Name: s2mm_axis_dma

Overview:
Parametrised stream-to-memory DMA engine and successor to the fixed 128-bit s2mm surrogate. It receives one AXI-Stream packet and writes it to a word-addressed BRAM port. Additions over the fixed version: generic data width, byte strobes on a partial final word, memory-side backpressure, tlast-based short/long packet detection with drain, abort, and a status/byte-count readback. It sits between the AXIS ingress (DMA/FIFO) and the accelerator's local BRAM.

Parameters:
DATA_W, 128, stream/memory word width in bits; multiple of 8, power of two, at least 32.
ADDR_W, 12, BRAM word-address width.
LEN_W, 32, width of the byte length and byte counters.
DRAIN_EN, 1, when 1 an over-length packet is drained to tlast; when 0 it is left in the stream.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  transfer request; sampled only in IDLE
abort  in  1  cancel current transfer
byte_len  in  LEN_W  bytes to write; sampled with start
base  in  ADDR_W  first word address; sampled with start
busy  out  1  high from the cycle after start until the done pulse
done  out  1  one-cycle completion pulse
err_short  out  1  tlast arrived before byte_len was reached; valid with done, held until next start
err_long  out  1  byte_len was reached without tlast; valid with done, held until next start
aborted  out  1  transfer ended by abort; valid with done, held until next start
xfer_bytes  out  LEN_W  bytes committed to memory; held until next start
wr_en  out  1  write request; held until accepted
wr_ready  in  1  memory accepts the write when wr_en && wr_ready
wr_addr  out  ADDR_W  write word address
wr_data  out  DATA_W  write data
wr_strb  out  DATA_W/8  byte enables
s_tdata  in  DATA_W  stream data
s_tvalid  in  1  stream valid
s_tready  out  1  stream ready
s_tlast  in  1  end of packet

Behaviour:
- Reset values (asynchronous): all outputs 0, state IDLE.
- WBYTES = DATA_W/8.
- States:
  - IDLE: on start, latch byte_len into bytes_left and base into the address counter, clear all status and xfer_bytes, then go to RUN. If byte_len==0, go to FIN instead.
  - RUN: accepting beats.
  - DRAIN: discarding beats until tlast.
  - FIN: wait for the last write to be accepted, then pulse done and return to IDLE.
- s_tready = (RUN && (!wr_en || wr_ready)) || DRAIN. s_tready is never high in IDLE or FIN.
- Beat accept in RUN (s_tvalid && s_tready):
  - Register data into wr_data, set wr_en=1.
  - wr_addr: first write = base, then +1 per write, wrapping modulo 2^ADDR_W.
  - wr_strb: all ones if bytes_left >= WBYTES; otherwise the low bytes_left bits set.
  - Latency: one cycle from stream handshake to wr_en.
  - Decrement bytes_left by min(bytes_left, WBYTES).
- xfer_bytes increments by popcount(wr_strb) on each wr_en && wr_ready.
- wr_en with its addr/data/strb is held stable until wr_ready. Stream and memory handshakes in the same cycle are allowed (full throughput, 1 word/clk).
- End conditions, evaluated on the accepted beat:
  - bytes_left <= WBYTES and tlast: go to FIN, no error.
  - bytes_left <= WBYTES and not tlast: set err_long; go to DRAIN if DRAIN_EN, else FIN.
  - bytes_left > WBYTES and tlast: set err_short; this beat is written with full strobes; go to FIN.
- DRAIN: beats are accepted and discarded (no writes). On the tlast beat, go to FIN.
- FIN: done=1 in the first cycle with wr_en==0 (the cycle after the final write handshake), state returns to IDLE and busy=0 in the same cycle. A start in that same cycle is ignored.
- abort (any non-IDLE state):
  - Next cycle: wr_en=0 (a pending write is dropped, not counted), aborted=1, done=1, go to IDLE.
  - The stream is not drained.
  - abort takes priority over a simultaneous beat or end condition.
- start while busy: ignored. abort in IDLE: ignored.
- rst mid-transfer: immediate return to reset values. The partial transfer is discarded and no done pulse is issued.

Test Plan:
- DATA_W=128, base=0x010, byte_len=64, 4 beats with tlast on beat 4, wr_ready=1 -> writes at 0x010..0x013, all strb=0xFFFF, done 1 cycle after the 4th write, xfer_bytes=64, no error flags.
- byte_len=40, 3 beats, tlast on beat 3 -> third write strb=0x00FF, xfer_bytes=40, no error.
- byte_len=64, tlast on beat 2 -> 2 writes, err_short=1, xfer_bytes=32; byte_len=32 with tlast on beat 5 and DRAIN_EN=1 -> 2 writes, beats 3-5 consumed, err_long=1, done after beat 5.
- wr_ready toggling 1-0-0-1 with s_tvalid held high -> s_tready low while a write stalls, no beat lost or duplicated, write addr/data/strb stable during the stall; base=0xFFE with 4 beats -> addresses FFE, FFF, 000, 001.
- abort asserted while wr_en is stalled -> next cycle wr_en=0, done=1, aborted=1, xfer_bytes excludes the dropped word; byte_len=0 -> done 1 cycle after start, no writes, s_tready never high.
- rst pulsed mid-transfer -> all outputs 0 immediately, no done pulse; a new start afterwards completes normally.

Source files
------------

// File: rtl/s2mm_axis_dma_if.sv
// Stream ingress and BRAM write port of the s2mm DMA, bundled for port lists.
// master = DMA engine side, slave = stream source / memory side.
interface s2mm_axis_dma_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 12
) ();
    logic [DATA_W-1:0]   s_tdata;
    logic                s_tvalid;
    logic                s_tready;
    logic                s_tlast;
    logic                wr_en;
    logic                wr_ready;
    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [DATA_W/8-1:0] wr_strb;

    modport master (
        input  s_tdata, s_tvalid, s_tlast, wr_ready,
        output s_tready, wr_en, wr_addr, wr_data, wr_strb
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast, wr_ready,
        input  s_tready, wr_en, wr_addr, wr_data, wr_strb
    );
endinterface

// File: rtl/s2mm_axis_dma.sv
// Writes one AXI-Stream packet to a word-addressed BRAM; 1 cycle stream-to-write latency.
// Backpressure: s_tready drops while a write is stalled by wr_ready; 1 word/clk when unstalled.
module s2mm_axis_dma #(
    parameter int DATA_W   = 128,
    parameter int ADDR_W   = 12,
    parameter int LEN_W    = 32,
    parameter bit DRAIN_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  byte_len,
    input  logic [ADDR_W-1:0] base,
    output logic              busy,
    output logic              done,
    output logic              err_short,
    output logic              err_long,
    output logic              aborted,
    output logic [LEN_W-1:0]  xfer_bytes,
    s2mm_axis_dma_if.master   bus
);
    localparam int               WBYTES   = DATA_W / 8;
    localparam logic [LEN_W-1:0] WBYTES_L = LEN_W'(WBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state_q, state_d;

    logic [LEN_W-1:0]  bytes_left;
    logic [ADDR_W-1:0] addr_cnt;
    logic [LEN_W-1:0]  take;
    logic [LEN_W-1:0]  commit_bytes;
    logic [WBYTES-1:0] strb_d;
    logic              wr_free, beat, last_word, start_ok, abort_ok;

    assign wr_free      = !bus.wr_en || bus.wr_ready;
    assign bus.s_tready = ((state_q == RUN) && wr_free) || (state_q == DRAIN);
    assign beat         = bus.s_tvalid && bus.s_tready;
    assign last_word    = bytes_left <= WBYTES_L;
    assign take         = last_word ? bytes_left : WBYTES_L;
    // A start landing on the done cycle belongs to the transfer that just ended.
    assign start_ok     = (state_q == IDLE) && start && !done;
    assign abort_ok     = (state_q != IDLE) && abort;

    always_comb begin
        strb_d       = '0;
        commit_bytes = '0;
        for (int i = 0; i < WBYTES; i++) begin
            strb_d[i]    = LEN_W'(i) < take;
            commit_bytes = commit_bytes + LEN_W'(bus.wr_strb[i]);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_ok) state_d = (byte_len == '0) ? FIN : RUN;
            RUN:     if (beat && (last_word || bus.s_tlast))
                         state_d = (last_word && !bus.s_tlast && DRAIN_EN) ? DRAIN : FIN;
            DRAIN:   if (beat && bus.s_tlast) state_d = FIN;
            FIN:     if (wr_free) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort_ok) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bytes_left  <= '0;
            addr_cnt    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            aborted     <= 1'b0;
            xfer_bytes  <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.wr_strb <= '0;
        end else begin
            done <= 1'b0;
            if (abort_ok) begin
                // Pending write is dropped uncounted; the stream is left as is.
                bus.wr_en <= 1'b0;
                aborted   <= 1'b1;
                done      <= 1'b1;
                busy      <= 1'b0;
            end else if (start_ok) begin
                bytes_left <= byte_len;
                addr_cnt   <= base;
                busy       <= 1'b1;
                err_short  <= 1'b0;
                err_long   <= 1'b0;
                aborted    <= 1'b0;
                xfer_bytes <= '0;
            end else if (state_q != IDLE) begin
                if (bus.wr_en && bus.wr_ready) begin
                    xfer_bytes <= xfer_bytes + commit_bytes;
                    bus.wr_en  <= 1'b0;
                end
                if ((state_q == RUN) && beat) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_addr <= addr_cnt;
                    bus.wr_data <= bus.s_tdata;
                    bus.wr_strb <= strb_d;
                    addr_cnt    <= addr_cnt + ADDR_W'(1);
                    bytes_left  <= bytes_left - take;
                    if (last_word && !bus.s_tlast) err_long  <= 1'b1;
                    if (!last_word && bus.s_tlast) err_short <= 1'b1;
                end
                if ((state_q == FIN) && wr_free) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_s2mm_axis_dma.sv
// Scoreboard bench for s2mm_axis_dma: directed cases plus randomized packets vs. a packet-level model.
module tb_s2mm_axis_dma;
    localparam int DW = 128;
    localparam int AW = 12;
    localparam int LW = 32;
    localparam int WB = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [LW-1:0] byte_len = '0;
    logic [AW-1:0] base = '0;
    logic          busy, done, err_short, err_long, aborted;
    logic [LW-1:0] xfer_bytes;

    s2mm_axis_dma_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    s2mm_axis_dma #(.DATA_W(DW), .ADDR_W(AW), .LEN_W(LW), .DRAIN_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_len(byte_len), .base(base),
        .busy(busy), .done(done), .err_short(err_short), .err_long(err_long),
        .aborted(aborted), .xfer_bytes(xfer_bytes), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [WB-1:0] strb;
    } wr_t;

    typedef struct {
        logic          es;
        logic          el;
        logic          ab;
        logic [LW-1:0] xfer;
    } st_t;

    wr_t wq[$];
    st_t sq[$];
    int  checks = 0;
    int  errors = 0;
    int  ready_mode = 0;   // 0 always ready, 1 random, 2 pattern 1-0-0-1, 3 manual
    int  cyc = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cyc++;
        case (ready_mode)
            0: bus.wr_ready = 1'b1;
            1: bus.wr_ready = ($urandom % 3) != 0;
            2: bus.wr_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            default: ;
        endcase
    end

    // Monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.wr_en) begin
                if (wq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_write: got addr %0h expected none", bus.wr_addr);
                end else begin
                    check("write", 256'({bus.wr_addr, bus.wr_data, bus.wr_strb}),
                          256'({wq[0].addr, wq[0].data, wq[0].strb}));
                    if (bus.wr_ready) void'(wq.pop_front());
                end
            end
            if (done) begin
                if (sq.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got done=1 expected 0");
                end else begin
                    check("status", 256'({busy, err_short, err_long, aborted, xfer_bytes}),
                          256'({1'b0, sq[0].es, sq[0].el, sq[0].ab, sq[0].xfer}));
                    void'(sq.pop_front());
                end
            end
        end
    end

    task automatic send_beat(input logic [DW-1:0] d, input logic last);
        int n = 0;
        bus.s_tdata  = d;
        bus.s_tlast  = last;
        bus.s_tvalid = 1'b1;
        @(negedge clk);
        while (!bus.s_tready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.s_tready) begin
            checks++; errors++;
            $display("FAIL beat_timeout: got s_tready=0 expected 1");
        end
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [LW-1:0] len);
        base     = b;
        byte_len = len;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        base     = AW'($urandom);
        byte_len = $urandom;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (sq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sq.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done expected done");
            sq.delete();
        end
        check("writes_drained", 256'(wq.size()), 256'(0));
        wq.delete();
    endtask

    // Model: tl = 1-based index of the tlast beat; words = ceil(len / WB).
    task automatic do_xfer(input logic [AW-1:0] b, input int len, input int tl,
                           input int gap_max, input int dup_start_at);
        int            words, nw, rem, g;
        logic [DW-1:0] d[$];
        wr_t           w;
        st_t           s;
        words = (len + WB - 1) / WB;
        nw    = (tl < words) ? tl : words;
        for (int k = 0; k < tl; k++) d.push_back({$urandom, $urandom, $urandom, $urandom});
        for (int k = 0; k < nw; k++) begin
            rem    = len - k * WB;
            w.addr = b + AW'(k);
            w.data = d[k];
            w.strb = (rem >= WB) ? '1 : WB'((1 << rem) - 1);
            wq.push_back(w);
        end
        s.es   = tl < words;
        s.el   = tl > words;
        s.ab   = 1'b0;
        s.xfer = (tl < words) ? LW'(tl * WB) : LW'(len);
        sq.push_back(s);
        pulse_start(b, LW'(len));
        for (int k = 0; k < tl; k++) begin
            g = $urandom_range(0, gap_max);
            repeat (g) begin @(posedge clk); #1; end
            if (k == dup_start_at) start = 1'b1;
            send_beat(d[k], k == tl - 1);
            start = 1'b0;
        end
        wait_done(300);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        wr_t           w;
        st_t           s;
        logic [DW-1:0] d0, d1;
        int            len, tl, words;

        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        bus.wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 256'({busy, done, err_short, err_long, aborted, xfer_bytes,
                                   bus.wr_en, bus.wr_addr, bus.wr_strb, bus.s_tready}), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        do_xfer(12'h010, 64, 4, 0, -1);
        do_xfer(12'h020, 40, 3, 0, -1);
        do_xfer(12'h030, 64, 2, 0, -1);
        do_xfer(12'h040, 32, 5, 0, -1);
        ready_mode = 2;
        do_xfer(12'h050, 64, 4, 0, 1);
        ready_mode = 0;
        do_xfer(12'hFFE, 64, 4, 0, -1);

        // Abort while the second write is stalled.
        d0 = {$urandom, $urandom, $urandom, $urandom};
        d1 = {$urandom, $urandom, $urandom, $urandom};
        w.strb = '1;
        w.addr = 12'h200; w.data = d0; wq.push_back(w);
        w.addr = 12'h201; w.data = d1; wq.push_back(w);
        s.es = 1'b0; s.el = 1'b0; s.ab = 1'b1; s.xfer = LW'(16);
        sq.push_back(s);
        pulse_start(12'h200, LW'(64));
        send_beat(d0, 1'b0);
        send_beat(d1, 1'b0);
        ready_mode   = 3;
        bus.wr_ready = 1'b0;
        @(posedge clk); #1;
        abort        = 1'b1;
        bus.s_tvalid = 1'b1;
        bus.s_tdata  = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        abort = 1'b0;
        void'(wq.pop_back());
        @(negedge clk);
        check("abort_wr_en", 256'(bus.wr_en), 256'(0));
        check("abort_done", 256'(done), 256'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_drain", 256'(bus.s_tready), 256'(0));
        end
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        ready_mode   = 0;
        wait_done(5);

        // Zero-length transfer with the stream offering data throughout.
        s.es = 1'b0; s.el = 1'b0; s.ab = 1'b0; s.xfer = '0;
        sq.push_back(s);
        bus.s_tvalid = 1'b1;
        pulse_start(12'h123, '0);
        @(negedge clk);
        check("zero_busy", 256'({busy, done, bus.s_tready}), 256'(3'b100));
        @(posedge clk); #1;
        @(negedge clk);
        check("zero_done", 256'({busy, done, bus.s_tready}), 256'(3'b010));
        @(posedge clk); #1;
        bus.s_tvalid = 1'b0;
        wait_done(5);

        // Asynchronous reset mid-transfer, then a clean transfer.
        d0 = {$urandom, $urandom, $urandom, $urandom};
        d1 = {$urandom, $urandom, $urandom, $urandom};
        w.strb = '1;
        w.addr = 12'h300; w.data = d0; wq.push_back(w);
        w.addr = 12'h301; w.data = d1; wq.push_back(w);
        pulse_start(12'h300, LW'(64));
        send_beat(d0, 1'b0);
        send_beat(d1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("rst_async", 256'({busy, done, err_short, err_long, aborted, xfer_bytes,
                                 bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_strb, bus.s_tready}),
              256'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        wq.delete();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_done", 256'({busy, done}), 256'(0));
        end
        @(posedge clk); #1;
        do_xfer(12'h400, 48, 3, 1, -1);

        for (int it = 0; it < 30; it++) begin
            ready_mode = $urandom_range(0, 2);
            len   = $urandom_range(1, 100);
            words = (len + WB - 1) / WB;
            tl    = words + $urandom_range(0, 4) - 2;
            if (tl < 1) tl = 1;
            do_xfer(AW'($urandom), len, tl, $urandom_range(0, 2), -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
